// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures the high time of an asynchronous pulse in CLK cycles.
// Define PULSE_WIDTH_METER_PERIOD_EN to add the rise-to-rise PERIOD output.
module pulse_width_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             PULSE_IN,
    output logic [CNT_W-1:0] WIDTH,
    output logic             VALID,
    output logic             OVF,
`ifdef PULSE_WIDTH_METER_PERIOD_EN
    output logic [CNT_W-1:0] PERIOD,
`endif
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_WIDTH);

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] warm_q;
    logic                   s_in;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic                   ready;
    logic                   start;
    logic                   accept;
    logic                   accept_q;
    logic [CNT_W-1:0]       count_q;
    logic                   ovf_q;

    // warm_q keeps IDLE from arming until s_in reflects samples taken after reset,
    // otherwise a pulse already high during reset would look like a fresh rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            s_d    <= 1'b0;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PULSE_IN};
            s_d    <= s_in;
            warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign s_in  = sync_q[SYNC_STAGES-1];
    assign rise  = s_in & ~s_d;
    assign fall  = ~s_in & s_d;
    assign ready = warm_q[SYNC_STAGES-1];
    assign BUSY  = (state_q == MEASURE);

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (EN && ready && !s_in) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!EN) begin
                    state_d = IDLE;
                end else if (rise) begin
                    state_d = MEASURE;
                    start   = 1'b1;
                end
            end
            MEASURE: begin
                if (!EN) begin
                    state_d = IDLE;
                end else if (fall) begin
                    state_d = ARMED;
                    accept  = (count_q >= MIN_VAL);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // count_q is frozen on the fall edge, so the result register one cycle later
    // still sees the final count even if a new pulse reloads it on that same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            accept_q <= 1'b0;
            WIDTH    <= '0;
            OVF      <= 1'b0;
            VALID    <= 1'b0;
        end else begin
            state_q  <= state_d;
            accept_q <= accept;
            VALID    <= accept_q;
            if (accept_q) begin
                WIDTH <= count_q;
                OVF   <= ovf_q;
            end
            if (start) begin
                count_q <= ONE;
                ovf_q   <= (CNT_MAX == ONE);
            end else if (state_q == MEASURE && s_in) begin
                if (count_q != CNT_MAX) begin
                    count_q <= count_q + ONE;
                end
                if (count_q >= CNT_MAX - ONE) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

`ifdef PULSE_WIDTH_METER_PERIOD_EN
    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] pcap_q;
    logic             prev_ok_q;

    // A period is only meaningful when the previous pulse was accepted and the
    // meter never dropped back to IDLE in between; otherwise report 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt_q    <= '0;
            pcap_q    <= '0;
            prev_ok_q <= 1'b0;
            PERIOD    <= '0;
        end else begin
            if (start) begin
                pcnt_q <= ONE;
                pcap_q <= prev_ok_q ? pcnt_q : '0;
            end else if (pcnt_q != CNT_MAX) begin
                pcnt_q <= pcnt_q + ONE;
            end
            if (state_d == IDLE) begin
                prev_ok_q <= 1'b0;
            end else if (state_q == MEASURE && state_d == ARMED) begin
                prev_ok_q <= accept;
            end
            if (accept_q) begin
                PERIOD <= pcap_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: scoreboard bench driving two meter configurations with the same input,
// one small-counter/no-filter (A) and one glitch-filtering with a 3-flop synchroniser (B).
module tb_pulse_width_meter;

    localparam int A_W = 4;
    localparam int A_S = 2;
    localparam int A_M = 1;
    localparam int B_W = 8;
    localparam int B_S = 3;
    localparam int B_M = 3;

    typedef struct {
        int width;
        int ovf;
        int period;
        int cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           pulse_in;
    logic [A_W-1:0] width_a;
    logic           valid_a;
    logic           ovf_a;
    logic           busy_a;
    logic [B_W-1:0] width_b;
    logic           valid_b;
    logic           ovf_b;
    logic           busy_b;
`ifdef PULSE_WIDTH_METER_PERIOD_EN
    logic [A_W-1:0] period_a;
    logic [B_W-1:0] period_b;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;
    int   prev_acc[2];
    int   last_rise;

    pulse_width_meter #(.CNT_W(A_W), .SYNC_STAGES(A_S), .MIN_WIDTH(A_M)) dut_a (
        .CLK(clk), .RST(rst), .EN(en), .PULSE_IN(pulse_in),
        .WIDTH(width_a), .VALID(valid_a), .OVF(ovf_a),
`ifdef PULSE_WIDTH_METER_PERIOD_EN
        .PERIOD(period_a),
`endif
        .BUSY(busy_a)
    );

    pulse_width_meter #(.CNT_W(B_W), .SYNC_STAGES(B_S), .MIN_WIDTH(B_M)) dut_b (
        .CLK(clk), .RST(rst), .EN(en), .PULSE_IN(pulse_in),
        .WIDTH(width_b), .VALID(valid_b), .OVF(ovf_b),
`ifdef PULSE_WIDTH_METER_PERIOD_EN
        .PERIOD(period_b),
`endif
        .BUSY(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: what one meter instance should report for a clean pulse.
    task automatic modelPush(input int inst, input int high, input int spacing, input int fall_cyc);
        int   max_v;
        int   min_v;
        int   sync_v;
        exp_t e;
        max_v  = (inst == 0) ? (1 << A_W) - 1 : (1 << B_W) - 1;
        min_v  = (inst == 0) ? A_M : B_M;
        sync_v = (inst == 0) ? A_S : B_S;
        e.width  = (high >= max_v) ? max_v : high;
        e.ovf    = (high >= max_v) ? 1 : 0;
        e.period = prev_acc[inst] ? ((spacing >= max_v) ? max_v : spacing) : 0;
        e.cyc    = fall_cyc + sync_v + 2;
        if (e.width >= min_v) begin
            if (inst == 0) q_a.push_back(e);
            else           q_b.push_back(e);
            prev_acc[inst] = 1;
        end else begin
            prev_acc[inst] = 0;
        end
    endtask

    task automatic applyStimulus(input int high, input int low);
        int rise_cyc;
        int fall_cyc;
        rise_cyc = cyc;
        pulse_in = 1'b1;
        tick(high);
        fall_cyc = cyc;
        pulse_in = 1'b0;
        modelPush(0, high, rise_cyc - last_rise, fall_cyc);
        modelPush(1, high, rise_cyc - last_rise, fall_cyc);
        last_rise = rise_cyc;
        tick(low);
    endtask

    always @(negedge clk) begin
        if (valid_a) begin
            if (q_a.size() == 0) begin
                checkOutput("A.unexpected_valid", 1, 0);
            end else begin
                ea = q_a.pop_front();
                checkOutput("A.width", int'(width_a), ea.width);
                checkOutput("A.ovf", int'(ovf_a), ea.ovf);
                checkOutput("A.latency_cycle", cyc, ea.cyc);
`ifdef PULSE_WIDTH_METER_PERIOD_EN
                checkOutput("A.period", int'(period_a), ea.period);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (q_b.size() == 0) begin
                checkOutput("B.unexpected_valid", 1, 0);
            end else begin
                eb = q_b.pop_front();
                checkOutput("B.width", int'(width_b), eb.width);
                checkOutput("B.ovf", int'(ovf_b), eb.ovf);
                checkOutput("B.latency_cycle", cyc, eb.cyc);
`ifdef PULSE_WIDTH_METER_PERIOD_EN
                checkOutput("B.period", int'(period_b), eb.period);
`endif
            end
        end
    end

    initial begin
        int drain;
        prev_acc[0] = 0;
        prev_acc[1] = 0;
        last_rise   = 0;

        $display("[TB] reset with input high and enable set");
        rst      = 1'b1;
        en       = 1'b1;
        pulse_in = 1'b1;
        tick(3);
        checkOutput("reset.A.width", int'(width_a), 0);
        checkOutput("reset.A.valid", int'(valid_a), 0);
        checkOutput("reset.A.ovf", int'(ovf_a), 0);
        checkOutput("reset.A.busy", int'(busy_a), 0);
        checkOutput("reset.B.width", int'(width_b), 0);
        checkOutput("reset.B.busy", int'(busy_b), 0);
        rst = 1'b0;
        tick(4);
        checkOutput("post_reset.A.busy", int'(busy_a), 0);
        checkOutput("post_reset.B.busy", int'(busy_b), 0);
        pulse_in = 1'b0;
        tick(8);

        $display("[TB] basic 10-cycle pulse");
        applyStimulus(10, 8);

        $display("[TB] back-to-back 3 high / 1 low / 7 high");
        applyStimulus(3, 1);
        applyStimulus(7, 8);

        $display("[TB] overflow and glitch filter");
        applyStimulus(20, 8);
        applyStimulus(2, 8);

        $display("[TB] enable dropped mid-pulse, restored while high");
        pulse_in = 1'b1;
        tick(4);
        checkOutput("abort.A.busy_before", int'(busy_a), 1);
        checkOutput("abort.B.busy_before", int'(busy_b), 1);
        en = 1'b0;
        tick(1);
        checkOutput("abort.A.busy_after", int'(busy_a), 0);
        checkOutput("abort.B.busy_after", int'(busy_b), 0);
        tick(1);
        en = 1'b1;
        tick(3);
        checkOutput("reenable.A.busy", int'(busy_a), 0);
        checkOutput("reenable.B.busy", int'(busy_b), 0);
        pulse_in = 1'b0;
        prev_acc[0] = 0;
        prev_acc[1] = 0;
        tick(8);

        $display("[TB] periodic 4 high / 6 low");
        repeat (4) applyStimulus(4, 6);

        drain = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && drain < 100) begin
            tick(1);
            drain++;
        end
        tick(2);
        checkOutput("A.pending_results", q_a.size(), 0);
        checkOutput("B.pending_results", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
